// File: rtl/eth_rx_fcs.sv
// rtl/eth_rx_fcs.sv - Ethernet receive frame checker: preamble/SFD strip, CRC32 residue check, FCS-stripping forward
module eth_rx_fcs #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        c,
    input  logic        r,
    input  logic        dv,
    input  logic        den,
    input  logic [7:0]  d,
    input  logic        er,
    output logic [7:0]  q,
    output logic        qv,
    output logic        sof,
    output logic        eof,
    output logic        good,
    output logic [10:0] len
);

    typedef enum logic [1:0] {IDLE, PRE, FRAME, DROP} state_t;

    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] dly_q, dly_d;     // [7:0] newest byte, [31:24] oldest
    logic [7:0]  q_q, q_d;
    logic        qv_q, qv_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        good_q, good_d;
    logic [10:0] len_q, len_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] cin, input logic [7:0] b);
        logic [31:0] x;
        x = cin ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dly_d   = dly_q;
        q_d     = q_q;
        qv_d    = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        good_d  = good_q;
        len_d   = len_q;
        case (state_q)
            // IDLE evaluates a byte strobed in the dv rise cycle exactly like PRE does
            IDLE, PRE: begin
                if (!dv) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRE;
                    if (den) begin
                        if (d == 8'hD5) begin
                            state_d = FRAME;
                            crc_d   = 32'hFFFFFFFF;
                            cnt_d   = '0;
                            err_d   = 1'b0;
                            dly_d   = '0;
                        end else if (d != 8'h55) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            FRAME: begin
                if (!dv) begin
                    state_d = IDLE;
                    eof_d   = 1'b1;
                    good_d  = (crc_q == RESIDUE) && (cnt_q >= MIN_L) &&
                              (cnt_q <= MAX_L) && !err_q;
                    len_d   = cnt_q;
                    dly_d   = '0;
                end else if (den) begin
                    crc_d = crc_byte(crc_q, d);
                    cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                    err_d = err_q | er;
                    dly_d = {dly_q[23:0], d};
                    if (cnt_q >= 11'd4) begin
                        qv_d  = 1'b1;
                        q_d   = dly_q[31:24];
                        sof_d = (cnt_q == 11'd4);
                    end
                end
            end
            DROP: begin
                if (!dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            crc_q   <= 32'hFFFFFFFF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dly_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            good_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dly_q   <= dly_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            good_q  <= good_d;
            len_q   <= len_d;
        end
    end

    assign q    = q_q;
    assign qv   = qv_q;
    assign sof  = sof_q;
    assign eof  = eof_q;
    assign good = good_q;
    assign len  = len_q;

endmodule

// File: doc/eth_rx_fcs.md
# eth_rx_fcs

Ethernet receive-side frame checker, the counterpart to the transmit-path CRC32 generator. It takes the byte stream from the MII/RMII nibble assembler and strips the preamble and SFD. It computes the CRC32 over the frame and forwards the frame body minus its 4-byte FCS to the packet parser through a 4-byte delay line. At frame end it reports good/bad status and the byte count.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1518: maximum legal frame length in bytes, DA through FCS inclusive.

- `c`  in  1  clock.
- `r`  in  1  reset, asynchronous, active-low.
- `dv`  in  1  carrier/data-valid level from PHY side, high for the whole frame.
- `den`  in  1  byte strobe; `d` is a new byte when `den` and `dv` are both high.
- `d`  in  8  received byte, bit 0 first on the wire.
- `er`  in  1  PHY receive error, sampled with `den`.
- `q`  out  8  forwarded frame byte.
- `qv`  out  1  one-cycle pulse per forwarded byte.
- `sof`  out  1  high with the first `qv` of a frame.
- `eof`  out  1  one-cycle end-of-frame pulse.
- `good`  out  1  valid only with `eof`; 1 = frame passed all checks.
- `len`  out  11  frame byte count after SFD, including FCS; valid with `eof`; saturates at 2047.

## Operation
- **Reset:**
  - State goes to IDLE.
  - All outputs are 0.
  - CRC register is 0xFFFFFFFF.
  - Byte counter, delay line and error flag are cleared.
- **States:** IDLE, PRE, FRAME, DROP.
  - **IDLE:** when `dv`=1, go to PRE. The byte in that same cycle, if strobed, is evaluated as in PRE.
  - **PRE:** on each strobed byte:
    - 0x55: stay in PRE.
    - 0xD5: go to FRAME, load CRC with 0xFFFFFFFF, clear counter and error flag.
    - Any other byte: go to DROP.
    - If `dv`=0 before SFD: go to IDLE, no `eof`.
  - **FRAME:** on each strobed byte:
    - Update CRC (reflected, LSB-first, polynomial 0xEDB88320, no final inversion inside the register).
    - Increment `len` (saturating at 2047).
    - OR `er` into the error flag.
    - Shift `d` into the 4-deep delay line.
  - **DROP:** wait for `dv`=0, then go to IDLE. No output and no `eof`.
- **Forwarding:**
  - Once the delay line holds 4 bytes, each further strobed byte pushes out the oldest byte on `q` with `qv`.
  - The first pushed-out byte carries `sof`.
  - The final 4 bytes (the FCS) are never forwarded.
- **End of frame:** the first cycle with `dv`=0 in FRAME raises `eof` on the next cycle and returns to IDLE.
  - `good` = 1 iff all of the following hold:
    - CRC register == 0xDEBB20E3 (residue);
    - `len` ≥ `MIN_LEN`;
    - `len` ≤ `MAX_LEN`;
    - error flag is 0.
  - Delay line is cleared.
- **Oversize frames:** forwarding continues past `MAX_LEN`; the only consequence is `good`=0.
- **Short frames:** a frame of fewer than 5 bytes produces no `qv` and no `sof`, but still produces `eof` with `good`=0.
- **Timing of `den` vs `dv`:** `den` is ignored while `dv`=0. A strobe in the same cycle that `dv` falls is not a byte.
- **Reset mid-frame:**
  - Everything clears immediately.
  - No `eof` is emitted for the interrupted frame.
  - The next frame is processed normally.

## Timing
- `q`, `qv`, `sof` are registered and appear 1 cycle after the strobe of byte n+4, for payload byte n.
- CRC update and counter increment take effect in the cycle after the strobe.
- `eof`, `good`, `len` are asserted exactly 1 cycle after the first `dv`=0 cycle in FRAME.
  - `eof` is high for 1 cycle.
  - `good` and `len` hold their values until the next `eof`.
- Back-to-back frames:
  - `dv` must be low for at least 1 cycle between frames.
  - A new `dv` rise in the cycle `eof` is driven must be accepted, i.e. the block is in IDLE that cycle.
- Throughput: one byte per cycle is supported (`den` tied high). No backpressure exists, so the downstream block must accept every `qv`.

## Test plan
- **Valid check-string frame:** `MIN_LEN`=1; stimulus is 7×0x55, 0xD5, ASCII "123456789", then 0x26 0x39 0xF4 0xCB, with `den`=1 each cycle.
  - Expect 9 `qv` carrying "123456789".
  - Expect `sof` on '1'.
  - Expect `eof` with `good`=1 and `len`=13.
- **Single-bit corruption:** same frame, FCS byte 0x26 replaced by 0x27 → `eof`, `good`=0, `len`=13, 9 bytes still forwarded.
- **Length checks:** default parameters with the same valid 13-byte frame → `good`=0 (short). A 1519-byte frame with correct FCS → `good`=0, `len`=1519.
- **Bad preamble:** 0x55, 0x12, 0xD5, then data → no `qv`, no `eof`. A valid frame following after `dv` drops gives `good`=1.
- **Reset and PHY error:**
  - Drive `r` low mid-FRAME → all outputs 0, no `eof`; the next valid frame is reported good.
  - Assert `er` on one byte of a valid frame → `good`=0.
- **Strobed input:** `den` every other cycle (MII rate) on the valid frame → the same 9 bytes are forwarded, each 1 cycle after the strobe of byte n+4, with `good`=1.
